// File: rtl/sync_fifo_if.sv
// Request/flag bundle between a sync_fifo and its producer/consumer.
// overflow/underflow exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
    parameter int p_width = 32,
    parameter int p_depth = 32
);
    localparam int c_cw = $clog2(p_depth) + 1;

    logic               wr_req;
    logic [p_width-1:0] wr_data;
    logic               full;
    logic               almost_full;
    logic               rd_req;
    logic [p_width-1:0] rd_data;
    logic               empty;
    logic               almost_empty;
    logic [c_cw-1:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic               overflow;
    logic               underflow;
`endif

    modport master (
        output wr_req, wr_data, rd_req,
        input  full, almost_full, rd_data, empty, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  wr_req, wr_data, rd_req,
        output full, almost_full, rd_data, empty, almost_empty, count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy flags.
// Optional SYNC_FIFO_ERR_FLAGS_EN adds registered overflow/underflow pulses.
module sync_fifo #(
    parameter int p_width             = 32,
    parameter int p_depth             = 32,
    parameter int p_early_flag_thresh = 4
) (
    input logic      clock,
    input logic      reset,
    sync_fifo_if.slave fifo
);
    localparam int c_aw = $clog2(p_depth);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full_lvl = c_cw'(p_depth);
    localparam logic [c_cw-1:0] c_af_lvl   = c_cw'(p_depth - p_early_flag_thresh);
    localparam logic [c_cw-1:0] c_ae_lvl   = c_cw'(p_early_flag_thresh);

    logic [p_width-1:0] r_mem [p_depth];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic               r_full;
    logic               r_almost_full;
    logic               r_empty;
    logic               r_almost_empty;

    logic               w_wa;
    logic               w_ra;
    logic [c_cw-1:0]    w_count_nxt;

    // A pop frees a slot in the same edge, so a write at full is taken when paired with a read.
    assign w_wa = fifo.wr_req & (~r_full | fifo.rd_req);
    assign w_ra = fifo.rd_req & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wa && !w_ra) begin
            w_count_nxt = r_count + c_cw'(1);
        end else if (!w_wa && w_ra) begin
            w_count_nxt = r_count - c_cw'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_wa && !reset) begin
            r_mem[r_wr_ptr] <= fifo.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wa) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_ra) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_full_lvl);
            r_almost_full  <= (w_count_nxt >= c_af_lvl);
            r_empty        <= (w_count_nxt == '0);
            r_almost_empty <= (w_count_nxt <= c_ae_lvl);
        end
    end

    assign fifo.rd_data      = r_mem[r_rd_ptr];
    assign fifo.count        = r_count;
    assign fifo.full         = r_full;
    assign fifo.almost_full  = r_almost_full;
    assign fifo.empty        = r_empty;
    assign fifo.almost_empty = r_almost_empty;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= fifo.wr_req & r_full & ~fifo.rd_req;
            r_underflow <= fifo.rd_req & r_empty;
        end
    end

    assign fifo.overflow  = r_overflow;
    assign fifo.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus queues expected pop data, a negedge monitor compares.
module tb_sync_fifo;
    localparam int W = 32;
    localparam int D = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_count  = 0;
    logic [W-1:0] sb[$];

    always #5 clock = ~clock;

    sync_fifo_if #(.p_width(W), .p_depth(D)) bus ();

    sync_fifo #(.p_width(W), .p_depth(D), .p_early_flag_thresh(4)) dut (
        .clock (clock),
        .reset (reset),
        .fifo  (bus.slave)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags();
        chk("count",        W'(bus.count),        W'(m_count));
        chk("empty",        W'(bus.empty),        W'(m_count == 0));
        chk("full",         W'(bus.full),         W'(m_count == 32));
        chk("almost_full",  W'(bus.almost_full),  W'(m_count >= 28));
        chk("almost_empty", W'(bus.almost_empty), W'(m_count <= 4));
    endtask

    // Model decides acceptance from its own occupancy; flags checked #1 after the edge.
    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
        logic wa, ra;
        bus.wr_req  = w;
        bus.rd_req  = r;
        bus.wr_data = d;
        wa = w && (m_count != D || r);
        ra = r && (m_count != 0);
        if (wa) sb.push_back(d);
        m_count = m_count + int'(wa) - int'(ra);
        @(posedge clock);
        #1;
        chk_flags();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_count = 0;
        sb.delete();
        chk_flags();
    endtask

    always @(negedge clock) begin
        if (!reset && bus.rd_req && !bus.empty) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_order: got %0h expected nothing (queue empty)", bus.rd_data);
            end else begin
                chk("pop_data", bus.rd_data, sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.wr_data = '0;
        @(posedge clock);
        do_reset();

        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, W'(i));
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);

        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, W'(32'h100 + i));
        cyc(1'b1, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, W'(32'h200 + i));
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, '0);

        cyc(1'b1, 1'b1, 32'hA5);
        chk("bypass_head", bus.rd_data, 32'hA5);
        cyc(1'b0, 1'b1, '0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, W'(32'h1000 * (k + 1) + i));
            for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, '0);
        end

        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, W'(32'h300 + i));
        do_reset();
        cyc(1'b1, 1'b0, 32'h55);
        chk("after_reset_head", bus.rd_data, 32'h55);
        cyc(1'b0, 1'b1, '0);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("underflow_idle", W'(bus.underflow), '0);
        cyc(1'b0, 1'b1, '0);
        chk("underflow_pulse", W'(bus.underflow), 1);
        cyc(1'b0, 1'b0, '0);
        chk("underflow_clear", W'(bus.underflow), '0);
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, W'(32'h400 + i));
        chk("overflow_idle", W'(bus.overflow), '0);
        cyc(1'b1, 1'b0, 32'hBAD);
        chk("overflow_pulse", W'(bus.overflow), 1);
        cyc(1'b0, 1'b0, '0);
        chk("overflow_clear", W'(bus.overflow), '0);
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, '0);
`endif

        cyc(1'b0, 1'b0, '0);
        chk("scoreboard_drained", W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
